// File: rtl/soc_pkg.sv
// Shared SoC definitions: register-bus data type and the input-port register map.
package soc_pkg;

  typedef logic [7:0] bus_data_t;

  localparam logic [1:0] GPIO_IN_DATA   = 2'd0;
  localparam logic [1:0] GPIO_IN_EDGE   = 2'd1;
  localparam logic [1:0] GPIO_IN_MASK   = 2'd2;
  localparam logic [1:0] GPIO_IN_STATUS = 2'd3;

endpackage

// File: rtl/input_debounce.sv
// One input bit: 2-FF synchronizer, stability counter, debounced value and
// a combinational rising-edge pulse aligned with the edge that updates db.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 48000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_48mhz,
  input  logic reset,
  input  logic pin,
  output logic db,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;
  logic             db_next;

  // Two-stage synchronizer for the asynchronous pin.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // db flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    db_next = db;
    if (sync2 != db && cnt == CNT_MAX) db_next = sync2;
  end

  assign rise = db_next & ~db;

  // Counter tracks the current run of differing samples; any agreeing
  // sample or an accepted change restarts it, so it never passes CNT_MAX.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      db  <= 1'b0;
    end else begin
      db <= db_next;
      if (sync2 == db || cnt == CNT_MAX) cnt <= '0;
      else                               cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gpio_input_port.sv
// Memory-mapped input port: debounced pins, sticky rising-edge flags with
// write-1-to-clear, interrupt mask and a registered level interrupt.
module gpio_input_port
  import soc_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 48000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk_48mhz,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins_in,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [1:0]       addr,
  input  logic [7:0]       wr_data,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             irq
);

  logic [WIDTH-1:0] db, rise;
  logic [WIDTH-1:0] edge_q, edge_next;
  logic [WIDTH-1:0] mask_q, mask_next;
  logic [WIDTH-1:0] clr;
  bus_data_t        rd_mux;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      input_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_db (
        .clk_48mhz(clk_48mhz),
        .reset    (reset),
        .pin      (pins_in[gi]),
        .db       (db[gi]),
        .rise     (rise[gi])
      );
    end
  endgenerate

  // Next state of flags and mask; a new rise beats a simultaneous clear.
  always_comb begin
    clr       = '0;
    mask_next = mask_q;
    if (wr_en && addr == GPIO_IN_EDGE) clr       = wr_data[WIDTH-1:0];
    if (wr_en && addr == GPIO_IN_MASK) mask_next = wr_data[WIDTH-1:0];
    edge_next = (edge_q & ~clr) | rise;
  end

  // Read mux sees pre-write contents; fields zero-extend to the bus width.
  always_comb begin
    rd_mux = '0;
    case (addr)
      GPIO_IN_DATA:   rd_mux[WIDTH-1:0] = db;
      GPIO_IN_EDGE:   rd_mux[WIDTH-1:0] = edge_q;
      GPIO_IN_MASK:   rd_mux[WIDTH-1:0] = mask_q;
      GPIO_IN_STATUS: rd_mux[0]         = irq;
      default:        rd_mux            = '0;
    endcase
  end

  // Register file, interrupt and read response.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      edge_q   <= '0;
      mask_q   <= '0;
      irq      <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      edge_q   <= edge_next;
      mask_q   <= mask_next;
      irq      <= |(edge_next & mask_next);
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gpio_input_port.sv
// Bench for gpio_input_port with DEBOUNCE_CYCLES=4: directed scenarios plus
// random traffic, all checked every cycle against a window-based model.
module tb_gpio_input_port;
  localparam int W  = 8;
  localparam int DC = 4;

  logic         clk_48mhz = 1'b0;
  logic         reset     = 1'b1;
  logic [W-1:0] pins_in   = '0;
  logic         rd_en     = 1'b0;
  logic         wr_en     = 1'b0;
  logic [1:0]   addr      = '0;
  logic [7:0]   wr_data   = '0;
  logic [7:0]   rd_data;
  logic         rd_valid;
  logic         irq;

  gpio_input_port #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk_48mhz(clk_48mhz),
    .reset    (reset),
    .pins_in  (pins_in),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .irq      (irq)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: pins reach the debouncer two clocks late; a bit's debounced value
  // takes the new level once the last DC delayed samples all disagree with it.
  logic [W-1:0] m_s1, m_s2, m_db, m_edge, m_mask;
  logic [7:0]   m_rd;
  logic         m_rv, m_irq;
  logic [W-1:0] hist[$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_edge = '0; m_mask = '0;
    m_rd = '0; m_rv = 1'b0; m_irq = 1'b0;
    hist.delete();
  endtask

  task automatic step(input logic re, input logic we, input logic [1:0] a, input logic [7:0] d);
    logic [W-1:0] nd, ne, nm, clr;
    rd_en = re; wr_en = we; addr = a; wr_data = d;
    hist.push_back(m_s2);
    if (hist.size() > DC) void'(hist.pop_front());
    nd = m_db;
    if (hist.size() == DC)
      for (int i = 0; i < W; i++) begin
        bit all_diff = 1'b1;
        foreach (hist[j]) if (hist[j][i] == m_db[i]) all_diff = 1'b0;
        if (all_diff) nd[i] = ~m_db[i];
      end
    clr = (we && a == 2'd1) ? d : '0;
    ne  = (m_edge & ~clr) | (nd & ~m_db);
    nm  = (we && a == 2'd2) ? d : m_mask;
    if (re)
      case (a)
        2'd0: m_rd = m_db;
        2'd1: m_rd = m_edge;
        2'd2: m_rd = m_mask;
        default: m_rd = {7'b0, m_irq};
      endcase
    m_rv = re; m_irq = |(ne & nm);
    m_db = nd; m_edge = ne; m_mask = nm;
    m_s2 = m_s1; m_s1 = pins_in;
    @(posedge clk_48mhz); #1;
    chk("rd_valid", rd_valid, m_rv);
    chk("irq", irq, m_irq);
    chk("rd_data", rd_data, m_rd);
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [7:0] exp);
    step(1'b1, 1'b0, a, 8'h00);
    chk(tag, rd_data, exp);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_48mhz);
    #1;
    chk("reset_rd_data", rd_data, 8'h00);
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_irq", irq, 1'b0);
    reset = 1'b0;
    idle(3);

    // Clean step on bit 0: six clocks pin-to-DATA.
    pins_in = 8'h01;
    idle(5);
    rd(2'd0, "data_before_latency", 8'h00);
    rd(2'd0, "data_after_latency", 8'h01);
    rd(2'd1, "edge_bit0", 8'h01);

    // Three-cycle glitch on bit 3 is rejected.
    pins_in = 8'h09; idle(3);
    pins_in = 8'h01; idle(8);
    rd(2'd0, "glitch_data", 8'h01);
    rd(2'd1, "glitch_edge", 8'h01);

    // Masked interrupt on bit 0.
    step(1'b0, 1'b1, 2'd1, 8'hFF);
    step(1'b0, 1'b1, 2'd2, 8'h01);
    pins_in = 8'h00; idle(8);
    chk("irq_after_fall", irq, 1'b0);
    pins_in = 8'h01; idle(5);
    chk("irq_pre_rise", irq, 1'b0);
    idle(1);
    chk("irq_on_rise", irq, 1'b1);
    step(1'b0, 1'b1, 2'd1, 8'h01);
    chk("irq_after_w1c", irq, 1'b0);
    rd(2'd1, "edge_after_w1c", 8'h00);

    // Unmasked rise on bit 1: flag only.
    step(1'b0, 1'b1, 2'd2, 8'h00);
    pins_in = 8'h03; idle(7);
    chk("irq_unmasked", irq, 1'b0);
    rd(2'd1, "edge_bit1", 8'h02);
    step(1'b0, 1'b1, 2'd1, 8'hFF);

    // W1C of bit 2 coincides with its rise: set wins.
    pins_in = 8'h07; idle(5);
    step(1'b0, 1'b1, 2'd1, 8'h04);
    rd(2'd1, "edge_set_wins", 8'h04);

    // Simultaneous read and write return pre-write contents.
    step(1'b1, 1'b1, 2'd2, 8'hFF);
    chk("rdwr_old_mask", rd_data, 8'h00);
    rd(2'd2, "mask_written", 8'hFF);
    step(1'b0, 1'b1, 2'd0, 8'h00);
    rd(2'd0, "data_write_ignored", 8'h07);
    rd(2'd3, "status_irq", 8'h01);

    // Reset mid-count with all pins high.
    step(1'b0, 1'b1, 2'd1, 8'hFF);
    step(1'b0, 1'b1, 2'd2, 8'h00);
    pins_in = 8'hFF; idle(2);
    reset = 1'b1; #2;
    model_reset();
    chk("async_rd_data", rd_data, 8'h00);
    chk("async_rd_valid", rd_valid, 1'b0);
    chk("async_irq", irq, 1'b0);
    @(posedge clk_48mhz); #1;
    reset = 1'b0;
    idle(5);
    rd(2'd0, "rst_data_pre", 8'h00);
    rd(2'd0, "rst_data_ff", 8'hFF);
    rd(2'd1, "rst_edge_ff", 8'hFF);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) pins_in = W'($urandom);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
